// File: rtl/pipelined_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_shifter_if
//
// Purpose: bundles the issue-side and writeback-side valid/ready channels of
// the pipelined barrel shifter into one interface.
//
// Signals:
//   in_valid   source -> shifter  operation present
//   in_ready   shifter -> source  shifter can take an operation this cycle
//   in_data    source -> shifter  operand, WIDTH bits
//   in_shamt   source -> shifter  shift amount, SHW bits (0..WIDTH-1)
//   in_mode    source -> shifter  00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  shifter -> sink    result present
//   out_ready  sink -> shifter    sink accepts the result
//   out_data   shifter -> sink    shifted result, WIDTH bits
//   out_zero   shifter -> sink    result is all zeros
//
// Modports:
//   master  the side that issues operations and consumes results
//   slave   the shifter itself
// ---------------------------------------------------------------------------
interface pipelined_shifter_if #(
   parameter int WIDTH = 16
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output in_shamt,
      output in_mode,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_zero
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  in_shamt,
      input  in_mode,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_zero
   );
endinterface

// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Purpose: fully pipelined barrel shifter supporting SLL, SRL, SRA and ROR.
// There are log2(WIDTH) stages; stage k conditionally shifts by 2^k and
// registers the word together with the mode, shift amount and the original
// operand MSB. A valid/ready handshake with per-stage backpressure lets
// bubbles collapse and keeps results in strict FIFO order.
//
// Parameters:
//   WIDTH  data width, power of two, at least 4 (must match the interface)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards everything in flight
//   bus    pipelined_shifter_if.slave: in_* issue channel, out_* result
//          channel, out_zero flag registered alongside the result
// ---------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipelined_shifter_if.slave    bus
);
   localparam int SHW  = $clog2(WIDTH);
   localparam int NSTG = SHW;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   // Per-stage registers
   logic [NSTG-1:0]  vQ;
   logic [WIDTH-1:0] dataQ  [NSTG];
   logic [SHW-1:0]   shamtQ [NSTG];
   logic [1:0]       modeQ  [NSTG];
   logic             signQ  [NSTG];
   logic             zeroQ;

   // What each stage would load: its upstream source and the shifted word
   logic             srcValid [NSTG];
   logic [WIDTH-1:0] srcData  [NSTG];
   logic [SHW-1:0]   srcShamt [NSTG];
   logic [1:0]       srcMode  [NSTG];
   logic             srcSign  [NSTG];
   logic [WIDTH-1:0] dataD    [NSTG];

   // rdy[k] means stage k may load this cycle; rdy[NSTG] is the sink
   logic [NSTG:0]    rdy;

   // One conditional shift step by a fixed amount. SRA fills with the sign
   // of the original operand carried down the pipe, which gives the same
   // result as the current MSB but keeps every stage identical.
   function automatic logic [WIDTH-1:0] shiftStep(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       mode,
      input logic             sign,
      input int               amt
   );
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] res;
      fill = ~({WIDTH{1'b1}} >> amt);
      case (mode)
         MODE_SLL: res = d << amt;
         MODE_SRL: res = d >> amt;
         MODE_SRA: res = (d >> amt) | (sign ? fill : '0);
         MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
         default:  res = d;
      endcase
      return res;
   endfunction

   // Ready chain from the sink back to the input. A stage can load when it
   // is empty or when its content moves on in the same cycle, so bubbles
   // collapse even while the output is stalled.
   always_comb begin
      rdy       = '0;
      rdy[NSTG] = bus.out_ready;
      for (int k = NSTG - 1; k >= 0; k--) begin
         rdy[k] = !vQ[k] || rdy[k+1];
      end
   end

   // Upstream source for each stage: the input port for stage 0, the
   // previous stage's registers otherwise.
   always_comb begin
      srcValid[0] = bus.in_valid;
      srcData[0]  = bus.in_data;
      srcShamt[0] = bus.in_shamt;
      srcMode[0]  = bus.in_mode;
      srcSign[0]  = bus.in_data[WIDTH-1];
      for (int k = 1; k < NSTG; k++) begin
         srcValid[k] = vQ[k-1];
         srcData[k]  = dataQ[k-1];
         srcShamt[k] = shamtQ[k-1];
         srcMode[k]  = modeQ[k-1];
         srcSign[k]  = signQ[k-1];
      end
   end

   // Stage k shifts by 2^k only when shift-amount bit k is set.
   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         dataD[k] = srcData[k];
         if (srcShamt[k][k]) begin
            dataD[k] = shiftStep(srcData[k], srcMode[k], srcSign[k], 1 << k);
         end
      end
   end

   // Stage registers. Loading a bubble clears the valid bit but leaves the
   // payload untouched, so operands are only captured on a real transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vQ    <= '0;
         zeroQ <= 1'b0;
         for (int k = 0; k < NSTG; k++) begin
            dataQ[k]  <= '0;
            shamtQ[k] <= '0;
            modeQ[k]  <= '0;
            signQ[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NSTG; k++) begin
            if (rdy[k]) begin
               vQ[k] <= srcValid[k];
               if (srcValid[k]) begin
                  dataQ[k]  <= dataD[k];
                  shamtQ[k] <= srcShamt[k];
                  modeQ[k]  <= srcMode[k];
                  signQ[k]  <= srcSign[k];
               end
            end
         end
         if (rdy[NSTG-1] && srcValid[NSTG-1]) begin
            zeroQ <= (dataD[NSTG-1] == '0);
         end
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vQ[NSTG-1];
   assign bus.out_data  = dataQ[NSTG-1];
   assign bus.out_zero  = zeroQ;

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Purpose: self-checking bench for pipelined_shifter at WIDTH=16. Directed
// vectors with hand-computed results, back-to-back streaming, backpressure,
// random stall traffic against a reference model, and reset mid-flight.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;
   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipelined_shifter_if #(.WIDTH(WIDTH)) bus ();

   pipelined_shifter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] data;
      logic [3:0]  shamt;
      logic [15:0] expData;
      logic        expZero;
   } vecT;

   typedef struct {
      logic [15:0] data;
      logic        zero;
      int          acceptEdge;
      logic        chkLat;
   } expT;

   vecT  vectors [13];
   expT  expQ [$];
   int   checks    = 0;
   int   failures  = 0;
   int   edgeNo    = 0;
   int   delivered = 0;

   // Reference shifter written independently of the staged structure
   function automatic logic [15:0] refShift(input logic [15:0] d, input logic [3:0] s,
                                            input logic [1:0] m);
      logic [31:0] dbl;
      logic [15:0] r;
      case (m)
         2'd0:    r = d << s;
         2'd1:    r = d >> s;
         2'd2:    r = $unsigned($signed(d) >>> s);
         default: begin
            dbl = {d, d} >> s;
            r   = dbl[15:0];
         end
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clock cycle: drive on the falling edge, settle, score any result
   // leaving on the coming rising edge, and record any accepted operation.
   task automatic applyStimulus(input logic iv, input logic [15:0] d, input logic [3:0] s,
                                input logic [1:0] m, input logic ordy,
                                input logic [15:0] expData, input logic expZero,
                                input logic chkLat, output logic accepted);
      expT e;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_shamt  = s;
      bus.in_mode   = m;
      bus.out_ready = ordy;
      #1;
      accepted = iv && bus.in_ready;
      if (bus.out_valid && ordy) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result: got 0x%0h expected none", bus.out_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_data", {16'h0, bus.out_data}, {16'h0, e.data});
            checkOutput("out_zero", {31'h0, bus.out_zero}, {31'h0, e.zero});
            if (e.chkLat) checkOutput("latency", edgeNo - e.acceptEdge, 4);
            delivered++;
         end
      end
      if (accepted) begin
         e.data       = expData;
         e.zero       = expZero;
         e.acceptEdge = edgeNo;
         e.chkLat     = chkLat;
         expQ.push_back(e);
      end
      @(posedge clk);
      edgeNo++;
   endtask

   task automatic drain(input int bound);
      logic acc;
      int   n;
      n = 0;
      while (expQ.size() != 0 && n < bound) begin
         applyStimulus(1'b0, 16'h0, 4'h0, 2'h0, 1'b1, 16'h0, 1'b0, 1'b0, acc);
         n++;
      end
      checkOutput("drain_empty", expQ.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        acc;
      logic [15:0] d;
      logic [3:0]  s;
      logic [1:0]  m;
      logic [15:0] r;
      logic [15:0] bpD [6];
      logic [3:0]  bpS [6];
      logic [1:0]  bpM [6];
      int          idx;
      int          n;
      int          base;
      int          accCount;

      vectors[0]  = '{2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
      vectors[1]  = '{2'd2, 16'h7FF0, 4'd4,  16'h07FF, 1'b0};
      vectors[2]  = '{2'd1, 16'h8000, 4'd15, 16'h0001, 1'b0};
      vectors[3]  = '{2'd0, 16'h0001, 4'd15, 16'h8000, 1'b0};
      vectors[4]  = '{2'd0, 16'h00F0, 4'd12, 16'h0000, 1'b1};
      vectors[5]  = '{2'd3, 16'h1234, 4'd4,  16'h4123, 1'b0};
      vectors[6]  = '{2'd3, 16'h8001, 4'd1,  16'hC000, 1'b0};
      vectors[7]  = '{2'd0, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
      vectors[8]  = '{2'd1, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
      vectors[9]  = '{2'd2, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
      vectors[10] = '{2'd3, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
      vectors[11] = '{2'd3, 16'h0001, 4'd15, 16'h0002, 1'b0};
      vectors[12] = '{2'd2, 16'h9000, 4'd3,  16'hF200, 1'b0};

      // Reset state
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_out_valid", {31'h0, bus.out_valid}, 0);
      checkOutput("reset_out_data", {16'h0, bus.out_data}, 0);
      checkOutput("reset_out_zero", {31'h0, bus.out_zero}, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_in_ready", {31'h0, bus.in_ready}, 1);

      // Directed vectors, one at a time, with latency check
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, vectors[i].data, vectors[i].shamt, vectors[i].mode, 1'b1,
                       vectors[i].expData, vectors[i].expZero, 1'b1, acc);
         checkOutput("vec_accept", {31'h0, acc}, 1);
         drain(20);
      end

      // Back-to-back stream: accepted every cycle, results every cycle
      base = delivered;
      for (int i = 0; i < 16; i++) begin
         d = 16'($urandom);
         s = 4'($urandom_range(0, 15));
         m = 2'($urandom_range(0, 3));
         r = refShift(d, s, m);
         applyStimulus(1'b1, d, s, m, 1'b1, r, r == 16'h0, 1'b1, acc);
         checkOutput("b2b_in_ready", {31'h0, acc}, 1);
      end
      drain(20);
      checkOutput("b2b_delivered", delivered - base, 16);

      // Backpressure: sink stalled, six operations offered
      for (int i = 0; i < 6; i++) begin
         bpD[i] = 16'($urandom);
         bpS[i] = 4'($urandom_range(1, 15));
         bpM[i] = 2'(i % 4);
      end
      base = delivered;
      idx  = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         applyStimulus(1'b1, bpD[idx], bpS[idx], bpM[idx], 1'b0,
                       refShift(bpD[idx], bpS[idx], bpM[idx]),
                       refShift(bpD[idx], bpS[idx], bpM[idx]) == 16'h0, 1'b0, acc);
         if (acc) idx++;
         #1;
         if (cyc >= 3) begin
            checkOutput("bp_hold_valid", {31'h0, bus.out_valid}, 1);
            checkOutput("bp_hold_data", {16'h0, bus.out_data},
                        {16'h0, refShift(bpD[0], bpS[0], bpM[0])});
         end
      end
      checkOutput("bp_accepted", idx, 4);
      checkOutput("bp_in_ready_full", {31'h0, bus.in_ready}, 0);
      n = 0;
      while (idx < 6 && n < 20) begin
         applyStimulus(1'b1, bpD[idx], bpS[idx], bpM[idx], 1'b1,
                       refShift(bpD[idx], bpS[idx], bpM[idx]),
                       refShift(bpD[idx], bpS[idx], bpM[idx]) == 16'h0, 1'b0, acc);
         if (acc) idx++;
         n++;
      end
      checkOutput("bp_all_accepted", idx, 6);
      drain(30);
      checkOutput("bp_delivered", delivered - base, 6);

      // Random traffic with random sink stalls
      base     = delivered;
      accCount = 0;
      n        = 0;
      d        = 16'($urandom);
      s        = 4'($urandom_range(0, 15));
      m        = 2'($urandom_range(0, 3));
      while (accCount < 1000 && n < 20000) begin
         r = refShift(d, s, m);
         applyStimulus(($urandom_range(0, 4) != 0), d, s, m, ($urandom_range(0, 2) != 0),
                       r, r == 16'h0, 1'b0, acc);
         if (acc) begin
            accCount++;
            d = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
         end
         n++;
      end
      checkOutput("rand_accepted", accCount, 1000);
      drain(40);
      checkOutput("rand_delivered", delivered - base, 1000);

      // Reset with operations in flight
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'h1111 * (i + 1), 4'd1, 2'd0, 1'b1, 16'h0, 1'b0, 1'b0, acc);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("pre_reset_out_valid", {31'h0, bus.out_valid}, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", {31'h0, bus.out_valid}, 0);
      checkOutput("midreset_out_data", {16'h0, bus.out_data}, 0);
      checkOutput("midreset_out_zero", {31'h0, bus.out_zero}, 0);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 16'h0, 4'h0, 2'h0, 1'b1, 16'h0, 1'b0, 1'b0, acc);
         #1;
         checkOutput("no_stale_result", {31'h0, bus.out_valid}, 0);
      end
      applyStimulus(1'b1, 16'hF000, 4'd4, 2'd1, 1'b1, 16'h0F00, 1'b0, 1'b1, acc);
      checkOutput("post_reset_accept", {31'h0, acc}, 1);
      drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
